// File: rtl/inst_loader.sv
// Boot loader for the host->board serial link: a length-prefixed program is written into
// instruction memory, then every later byte is queued for the core's IN instruction.
module inst_loader #(
    parameter int INST_SIZE = 14,
    parameter int FIFO_LOG  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 imem_we,
    output logic [INST_SIZE-1:0] imem_addr,
    output logic [31:0]          imem_wdata,
    output logic                 load_done,
    output logic                 load_err,
    input  logic                 in_pop,
    output logic [7:0]           in_data,
    output logic                 in_empty,
    output logic                 overflow
);
    localparam int          DEPTH = 1 << FIFO_LOG;
    localparam logic [32:0] CAP   = 33'd1 << INST_SIZE;

    typedef enum logic [1:0] {ST_HDR, ST_BODY, ST_RUN} state_t;

    state_t                 state_reg, state_next;
    logic [1:0]             byte_cnt_reg;
    logic [23:0]            shift_reg;
    logic [31:0]            count_reg;
    logic [31:0]            idx_reg;
    logic                   imem_we_reg;
    logic [INST_SIZE-1:0]   imem_addr_reg;
    logic [31:0]            imem_wdata_reg;
    logic                   done_reg, done_pend_reg, err_reg;

    logic [31:0] word;
    logic        last_byte;
    logic        wr_fire, body_done, hdr_zero, hdr_err;

    assign word      = {shift_reg, rx_data};
    assign last_byte = rx_valid && (byte_cnt_reg == 2'd3);

    always_comb begin
        state_next = state_reg;
        wr_fire    = 1'b0;
        body_done  = 1'b0;
        hdr_zero   = 1'b0;
        hdr_err    = 1'b0;
        case (state_reg)
            ST_HDR: begin
                if (last_byte) begin
                    hdr_err = ({1'b0, word} > CAP);
                    if (word == 32'd0) begin
                        state_next = ST_RUN;
                        hdr_zero   = 1'b1;
                    end else begin
                        state_next = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (last_byte) begin
                    // Words past the end of memory are swallowed so the stream stays aligned.
                    wr_fire = ((idx_reg >> INST_SIZE) == 32'd0);
                    if (idx_reg + 32'd1 == count_reg) begin
                        state_next = ST_RUN;
                        body_done  = 1'b1;
                    end
                end
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_HDR;
            byte_cnt_reg   <= 2'd0;
            shift_reg      <= 24'd0;
            count_reg      <= 32'd0;
            idx_reg        <= 32'd0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= 32'd0;
            done_reg       <= 1'b0;
            done_pend_reg  <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            imem_we_reg   <= wr_fire;
            // load_done trails the final write pulse by one cycle.
            done_pend_reg <= body_done;
            done_reg      <= done_reg | hdr_zero | done_pend_reg;
            err_reg       <= err_reg | hdr_err;
            if (rx_valid && state_reg != ST_RUN) begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
                shift_reg    <= {shift_reg[15:0], rx_data};
            end
            if (state_reg == ST_HDR && last_byte) begin
                count_reg <= word;
                idx_reg   <= 32'd0;
            end
            if (state_reg == ST_BODY && last_byte) begin
                idx_reg <= idx_reg + 32'd1;
            end
            if (wr_fire) begin
                imem_addr_reg  <= idx_reg[INST_SIZE-1:0];
                imem_wdata_reg <= word;
            end
        end
    end

    assign imem_we    = imem_we_reg;
    assign imem_addr  = imem_addr_reg;
    assign imem_wdata = imem_wdata_reg;
    assign load_done  = done_reg;
    assign load_err   = err_reg;

    logic [7:0]        fifo_mem [DEPTH];
    logic [FIFO_LOG:0] wr_ptr_reg, rd_ptr_reg;
    logic              overflow_reg;
    logic              fifo_empty, fifo_full, push_req, pop_ok, push_ok;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[FIFO_LOG] != rd_ptr_reg[FIFO_LOG]) &&
                        (wr_ptr_reg[FIFO_LOG-1:0] == rd_ptr_reg[FIFO_LOG-1:0]);
    assign push_req   = rx_valid && (state_reg == ST_RUN);
    assign pop_ok     = in_pop && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok    = push_req && (!fifo_full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg[FIFO_LOG-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            overflow_reg <= overflow_reg | (push_req && !push_ok);
        end
    end

    assign in_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg[FIFO_LOG-1:0]];
    assign in_empty = fifo_empty;
    assign overflow = overflow_reg;
endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: two instances (default and 4-word memory) share one byte stream
// and are compared every cycle against a byte-count/queue model, plus literal spot checks.
module tb_inst_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, rx_valid = 1'b0, in_pop = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic        a_we, a_done, a_err, a_empty, a_ovf;
    logic [13:0] a_addr;
    logic [31:0] a_wdata;
    logic [7:0]  a_data;
    logic        b_we, b_done, b_err, b_empty, b_ovf;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [7:0]  b_data;

    inst_loader dut_a (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .load_done(a_done), .load_err(a_err), .in_pop(in_pop),
        .in_data(a_data), .in_empty(a_empty), .overflow(a_ovf)
    );

    inst_loader #(.INST_SIZE(2), .FIFO_LOG(4)) dut_b (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .load_done(b_done), .load_err(b_err), .in_pop(in_pop),
        .in_data(b_data), .in_empty(b_empty), .overflow(b_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: memory capacity per instance; the loader is described by bytes seen since reset.
    longint      m_cap [2] = '{16384, 4};
    int          m_nb [2];
    logic [31:0] m_acc [2];
    longint      m_n [2], m_widx [2], m_addr [2];
    logic [31:0] m_wdata [2];
    bit          m_run [2], m_we [2], m_done [2], m_pend [2], m_err [2], m_ovf [2];
    logic [7:0]  m_q [2][$];

    task automatic model_step(input int i);
        bit pop_ok;
        if (rst) begin
            m_nb[i] = 0; m_acc[i] = 0; m_n[i] = 0; m_widx[i] = 0; m_addr[i] = 0;
            m_wdata[i] = 0; m_run[i] = 0; m_we[i] = 0; m_done[i] = 0; m_pend[i] = 0;
            m_err[i] = 0; m_ovf[i] = 0; m_q[i].delete();
            return;
        end
        m_we[i] = 0;
        if (m_pend[i]) m_done[i] = 1;
        m_pend[i] = 0;
        pop_ok = in_pop && (m_q[i].size() != 0);
        if (pop_ok) void'(m_q[i].pop_front());
        if (rx_valid) begin
            if (m_run[i]) begin
                if (m_q[i].size() < 16) m_q[i].push_back(rx_data);
                else m_ovf[i] = 1;
            end else begin
                m_acc[i] = {m_acc[i][23:0], rx_data};
                m_nb[i]++;
                if (m_nb[i] == 4) begin
                    m_n[i] = longint'(m_acc[i]);
                    m_widx[i] = 0;
                    if (m_n[i] > m_cap[i]) m_err[i] = 1;
                    if (m_n[i] == 0) begin m_run[i] = 1; m_done[i] = 1; end
                end else if (m_nb[i] % 4 == 0) begin
                    if (m_widx[i] < m_cap[i]) begin
                        m_we[i] = 1; m_addr[i] = m_widx[i] % m_cap[i]; m_wdata[i] = m_acc[i];
                    end
                    m_widx[i]++;
                    if (m_widx[i] == m_n[i]) begin m_run[i] = 1; m_pend[i] = 1; end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("a_imem_we",    a_we,    m_we[0]);
            chk("a_imem_addr",  a_addr,  m_addr[0]);
            chk("a_imem_wdata", a_wdata, m_wdata[0]);
            chk("a_load_done",  a_done,  m_done[0]);
            chk("a_load_err",   a_err,   m_err[0]);
            chk("a_in_empty",   a_empty, m_q[0].size() == 0);
            chk("a_in_data",    a_data,  (m_q[0].size() == 0) ? 8'h00 : m_q[0][0]);
            chk("a_overflow",   a_ovf,   m_ovf[0]);
            chk("b_imem_we",    b_we,    m_we[1]);
            chk("b_imem_addr",  b_addr,  m_addr[1]);
            chk("b_imem_wdata", b_wdata, m_wdata[1]);
            chk("b_load_done",  b_done,  m_done[1]);
            chk("b_load_err",   b_err,   m_err[1]);
            chk("b_in_empty",   b_empty, m_q[1].size() == 0);
            chk("b_in_data",    b_data,  (m_q[1].size() == 0) ? 8'h00 : m_q[1][0]);
            chk("b_overflow",   b_ovf,   m_ovf[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic p);
        rx_valid = v; rx_data = d; in_pop = p;
        tick();
        rx_valid = 0; in_pop = 0;
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send(w[8*k +: 8]);
    endtask

    task automatic do_reset();
        rst = 1; rx_valid = 1; rx_data = 8'hFF;
        tick();
        tick();
        rst = 0; rx_valid = 0;
        checking = 1;
    endtask

    initial begin
        do_reset();
        chk("reset_we",    a_we,    0);
        chk("reset_done",  a_done,  0);
        chk("reset_empty", a_empty, 1);
        chk("reset_wdata", a_wdata, 0);

        // Two-word program.
        send_word(32'h0000_0002);
        send_word(32'h7123_4567);
        chk("t1_we0", a_we, 1);
        chk("t1_addr0", a_addr, 0);
        chk("t1_wdata0", a_wdata, 32'h7123_4567);
        send_word(32'h1000_002A);
        chk("t1_we1", a_we, 1);
        chk("t1_addr1", a_addr, 1);
        chk("t1_wdata1", a_wdata, 32'h1000_002A);
        chk("t1_done_late", a_done, 0);
        tick();
        chk("t1_done", a_done, 1);
        chk("t1_we_off", a_we, 0);
        chk("t1_wdata_hold", a_wdata, 32'h1000_002A);

        // Empty program, then one run-mode byte.
        do_reset();
        send_word(32'h0);
        chk("t2_done", a_done, 1);
        chk("t2_empty_before", a_empty, 1);
        send(8'h41);
        chk("t2_empty", a_empty, 0);
        chk("t2_data", a_data, 8'h41);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t2_popped", a_empty, 1);

        // Overflow: 17 bytes into a 16-deep FIFO.
        do_reset();
        send_word(32'h0);
        for (int k = 0; k < 17; k++) send(8'(k));
        chk("t3_overflow", a_ovf, 1);
        for (int k = 0; k < 16; k++) begin
            chk("t3_order", a_data, k);
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("t3_drained", a_empty, 1);

        // Push+pop when full, then when empty.
        do_reset();
        send_word(32'h0);
        for (int k = 0; k < 16; k++) send(8'(k));
        cyc(1'b1, 8'hEE, 1'b1);
        chk("t4_no_overflow", a_ovf, 0);
        chk("t4_head", a_data, 8'h01);
        for (int k = 0; k < 15; k++) cyc(1'b0, 8'h00, 1'b1);
        chk("t4_last", a_data, 8'hEE);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t4_empty", a_empty, 1);
        cyc(1'b1, 8'h5A, 1'b1);
        chk("t4_push_empty", a_empty, 0);
        chk("t4_push_data", a_data, 8'h5A);

        // Reset in the middle of a word aborts the load.
        do_reset();
        send_word(32'h0000_0003);
        send(8'h11);
        send(8'h22);
        do_reset();
        chk("t5_we", a_we, 0);
        chk("t5_addr", a_addr, 0);
        chk("t5_done", a_done, 0);
        send_word(32'h0000_0001);
        send_word(32'hAABB_CCDD);
        chk("t5_we1", a_we, 1);
        chk("t5_wdata", a_wdata, 32'hAABB_CCDD);
        tick();
        chk("t5_done1", a_done, 1);

        // Program longer than the small instance's 4-word memory.
        do_reset();
        send_word(32'h0000_0005);
        chk("t6_err_small", b_err, 1);
        chk("t6_err_big", a_err, 0);
        for (int k = 0; k < 5; k++) begin
            send_word(32'hC0DE_0000 + 32'(k));
            if (k == 3) begin
                chk("t6_we3", b_we, 1);
                chk("t6_addr3", b_addr, 3);
            end
        end
        chk("t6_we_skip", b_we, 0);
        chk("t6_wdata_hold", b_wdata, 32'hC0DE_0003);
        chk("t6_big_addr4", a_addr, 4);
        tick();
        chk("t6_done", b_done, 1);
        tick();

        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
